// File: rtl/trans_sched.sv
// Memory-test sequencer: generates the address stream for one test and issues
// write/read burst commands to the AMM transmitter over a valid/ready handshake.
module trans_sched #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned BURST_W = 11,
  parameter int unsigned ALIGN_W = 6,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [1:0]         test_mode_i,
  input  logic [2:0]         addr_mode_i,
  input  logic [BURST_W-1:0] words_i,
  input  logic [CNT_W-1:0]   trans_count_i,
  input  logic [ADDR_W-1:0]  fix_addr_i,
  input  logic [31:0]        rnd_seed_i,
  input  logic               err_i,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic               cmd_write_o,
  output logic [ADDR_W-1:0]  cmd_addr_o,
  output logic [BURST_W-1:0] cmd_words_o,
  output logic               busy_o,
  output logic               finish_o,
  output logic               test_err_o,
  output logic [CNT_W-1:0]   trans_cnt_o
);

  localparam int unsigned IDX_W = 6;
  localparam logic [1:0] TM_NONE  = 2'b00;
  localparam logic [1:0] TM_WRCHK = 2'b11;
  localparam logic [2:0] AM_RND  = 3'd1;
  localparam logic [2:0] AM_RUN0 = 3'd2;
  localparam logic [2:0] AM_RUN1 = 3'd3;
  localparam logic [2:0] AM_INC  = 3'd4;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_W) - ADDR_W'(1));

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_DONE} state_t;

  state_t             state_q;
  logic [1:0]         mode_q;
  logic [2:0]         amode_q;
  logic [BURST_W-1:0] words_q;
  logic [CNT_W-1:0]   count_q, cnt_q;
  logic [ADDR_W-1:0]  base_q, off_q, addr_q;
  logic [31:0]        lfsr_q;
  logic [IDX_W-1:0]   bit_q;
  logic               valid_q, write_q, busy_q, finish_q, err_q, abort_q;

  logic [BURST_W-1:0] words_eff;
  logic [31:0]        seed_eff, lfsr_d;
  logic [ADDR_W-1:0]  addr_st_d, off_d, addr_d;
  logic [IDX_W-1:0]   bit_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               hs, abort_now, pair_wr, run_st, go_done;

  // Address for one iteration from the generator state; alignment bits cleared.
  function automatic logic [ADDR_W-1:0] gen_addr(input logic [2:0]        am,
                                                 input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] off,
                                                 input logic [31:0]       lfsr,
                                                 input logic [IDX_W-1:0]  k);
    logic [ADDR_W-1:0] one_hot;
    logic [ADDR_W-1:0] a;
    one_hot = ADDR_W'(1) << k;
    case (am)
      AM_RND:  a = lfsr[ADDR_W-1:0];
      AM_RUN0: a = ~one_hot;
      AM_RUN1: a = one_hot;
      AM_INC:  a = base + off;
      default: a = base;
    endcase
    return a & ALIGN_MASK;
  endfunction

  always_comb begin
    words_eff = (words_i == '0) ? BURST_W'(1) : words_i;
    seed_eff  = (rnd_seed_i == '0) ? 32'd1 : rnd_seed_i;
    addr_st_d = gen_addr(addr_mode_i, fix_addr_i, '0, seed_eff, IDX_W'(ALIGN_W));
    off_d     = off_q + (ADDR_W'(words_q) << ALIGN_W);
    lfsr_d    = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    bit_d     = (bit_q == IDX_W'(ADDR_W - 1)) ? IDX_W'(ALIGN_W) : bit_q + IDX_W'(1);
    addr_d    = gen_addr(amode_q, base_q, off_d, lfsr_d, bit_d);
    cnt_d     = cnt_q + CNT_W'(1);
    hs        = valid_q & cmd_ready_i;
    abort_now = abort_q | err_i;
    run_st    = (state_q == ST_WR) || (state_q == ST_RD);
    pair_wr   = (state_q == ST_WR) && (mode_q == TM_WRCHK);
    // A write of a WR+check pair only ends the test on abort; otherwise the
    // iteration completes on this handshake and may be the last one.
    go_done   = (state_q == ST_IDLE && start_i &&
                 (trans_count_i == '0 || test_mode_i == TM_NONE)) ||
                (run_st && hs && (abort_now || (!pair_wr && cnt_d == count_q))) ||
                (run_st && !valid_q && abort_now);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      amode_q  <= '0;
      words_q  <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      base_q   <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      lfsr_q   <= 32'd1;
      bit_q    <= IDX_W'(ALIGN_W);
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mode_q  <= test_mode_i;
            amode_q <= addr_mode_i;
            words_q <= words_eff;
            count_q <= trans_count_i;
            base_q  <= fix_addr_i;
            off_q   <= '0;
            lfsr_q  <= seed_eff;
            bit_q   <= IDX_W'(ALIGN_W);
            cnt_q   <= '0;
            err_q   <= (test_mode_i == TM_NONE);
            abort_q <= 1'b0;
            state_q <= test_mode_i[1] ? ST_WR : ST_RD;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            write_q <= test_mode_i[1];
            addr_q  <= addr_st_d;
          end
        end
        ST_WR, ST_RD: begin
          if (err_i) begin
            err_q   <= 1'b1;
            abort_q <= 1'b1;
          end
          if (hs) begin
            if (pair_wr) begin
              state_q <= ST_RD;
              write_q <= 1'b0;
            end else begin
              cnt_q   <= cnt_d;
              off_q   <= off_d;
              lfsr_q  <= lfsr_d;
              bit_q   <= bit_d;
              state_q <= mode_q[1] ? ST_WR : ST_RD;
              write_q <= mode_q[1];
              addr_q  <= addr_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (go_done) begin
        state_q  <= ST_DONE;
        valid_q  <= 1'b0;
        write_q  <= 1'b0;
        busy_q   <= 1'b0;
        finish_q <= 1'b1;
        abort_q  <= 1'b0;
      end
    end
  end

  assign cmd_valid_o = valid_q;
  assign cmd_write_o = write_q;
  assign cmd_addr_o  = addr_q;
  assign cmd_words_o = words_q;
  assign busy_o      = busy_q;
  assign finish_o    = finish_q;
  assign test_err_o  = err_q;
  assign trans_cnt_o = cnt_q;

endmodule

// File: tb/tb_trans_sched.sv
// Directed bench for trans_sched: main instance with ALIGN_W=6 plus an
// ALIGN_W=0 instance sharing the inputs for the unaligned LFSR sequence.
module tb_trans_sched;

  localparam logic [2:0] AM_FIX  = 3'd0;
  localparam logic [2:0] AM_RND  = 3'd1;
  localparam logic [2:0] AM_RUN0 = 3'd2;
  localparam logic [2:0] AM_RUN1 = 3'd3;
  localparam logic [2:0] AM_INC  = 3'd4;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [10:0] n;
    int          c;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n, start, err, ready;
  logic [1:0]  test_mode;
  logic [2:0]  addr_mode;
  logic [10:0] words;
  logic [31:0] trans_count, fix_addr, rnd_seed;

  logic        valid, write, busy, finish, terr;
  logic [31:0] addr, tcnt;
  logic [10:0] nwords;
  logic        v0, w0, b0, f0, e0;
  logic [31:0] a0, c0;
  logic [10:0] n0;

  cmd_t q[$];
  cmd_t q0[$];
  int   fin_idx;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  trans_sched #(.ADDR_W(32), .BURST_W(11), .ALIGN_W(6), .CNT_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .test_mode_i(test_mode),
    .addr_mode_i(addr_mode), .words_i(words), .trans_count_i(trans_count),
    .fix_addr_i(fix_addr), .rnd_seed_i(rnd_seed), .err_i(err),
    .cmd_valid_o(valid), .cmd_ready_i(ready), .cmd_write_o(write),
    .cmd_addr_o(addr), .cmd_words_o(nwords), .busy_o(busy), .finish_o(finish),
    .test_err_o(terr), .trans_cnt_o(tcnt));

  trans_sched #(.ADDR_W(32), .BURST_W(11), .ALIGN_W(0), .CNT_W(32)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .test_mode_i(test_mode),
    .addr_mode_i(addr_mode), .words_i(words), .trans_count_i(trans_count),
    .fix_addr_i(fix_addr), .rnd_seed_i(rnd_seed), .err_i(err),
    .cmd_valid_o(v0), .cmd_ready_i(ready), .cmd_write_o(w0),
    .cmd_addr_o(a0), .cmd_words_o(n0), .busy_o(b0), .finish_o(f0),
    .test_err_o(e0), .trans_cnt_o(c0));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start_test(input logic [1:0] tm, input logic [2:0] am, input logic [10:0] w,
                            input logic [31:0] cnt, input logic [31:0] fa, input logic [31:0] seed);
    @(negedge clk);
    test_mode = tm; addr_mode = am; words = w; trans_count = cnt;
    fix_addr = fa; rnd_seed = seed; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Record handshakes (sampled at negedge) until finish_o or the cycle budget runs out.
  task automatic collect(input int max_cyc);
    q.delete(); q0.delete(); fin_idx = -1;
    for (int c = 0; c < max_cyc; c++) begin
      if (valid && ready) q.push_back('{write, addr, nwords, c});
      if (v0 && ready) q0.push_back('{w0, a0, n0, c});
      if (finish) begin fin_idx = c; break; end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    logic [31:0] rnd_exp [4];
    logic        fin_any;
    rnd_exp = '{32'h1, 32'h3, 32'h6, 32'hD};
    rst_n = 1'b0; start = 1'b0; err = 1'b0; ready = 1'b1;
    test_mode = '0; addr_mode = '0; words = '0; trans_count = '0; fix_addr = '0; rnd_seed = '0;
    repeat (2) @(negedge clk);
    check_val("reset_outs", {valid, write, addr, nwords, busy, finish, terr, tcnt}, '0);
    rst_n = 1'b1;

    // WR+check, fixed address: six back-to-back commands
    start_test(2'b11, AM_FIX, 11'd4, 32'd3, 32'h1000, 32'd0);
    check_val("t1_busy", busy, 1);
    collect(50);
    check_val("t1_ncmd", q.size(), 6);
    for (int i = 0; i < q.size(); i++) begin
      check_val($sformatf("t1_cmd%0d", i), {q[i].w, q[i].a, q[i].n, q[i].c},
                {(i % 2 == 0), 32'h1000, 11'd4, i});
    end
    check_val("t1_fin_idx", fin_idx, 6);
    check_val("t1_cnt", tcnt, 3);
    check_val("t1_busy_end", busy, 0);
    @(negedge clk);
    check_val("t1_fin_pulse", finish, 0);

    // Write-only, incrementing
    start_test(2'b10, AM_INC, 11'd2, 32'd4, 32'h0, 32'd0);
    collect(50);
    check_val("t2_ncmd", q.size(), 4);
    for (int i = 0; i < q.size(); i++) begin
      e = 32'h80 * i;
      check_val($sformatf("t2_cmd%0d", i), {q[i].w, q[i].a, q[i].n}, {1'b1, e, 11'd2});
    end
    check_val("t2_cnt", tcnt, 4);

    // Read-only, running one with wrap
    start_test(2'b01, AM_RUN1, 11'd1, 32'd28, 32'h0, 32'd0);
    collect(100);
    check_val("t3_ncmd", q.size(), 28);
    for (int i = 0; i < q.size(); i++) begin
      e = 32'h1 << (6 + (i % 26));
      check_val($sformatf("t3_cmd%0d", i), {q[i].w, q[i].a}, {1'b0, e});
    end
    check_val("t3_cnt", tcnt, 28);

    start_test(2'b01, AM_RUN0, 11'd1, 32'd1, 32'h0, 32'd0);
    collect(20);
    check_val("t3_run0_n", q.size(), 1);
    if (q.size() > 0) check_val("t3_run0_addr", q[0].a, 32'hFFFF_FF80);

    // LFSR stream on the unaligned instance, zero seed
    start_test(2'b01, AM_RND, 11'd0, 32'd4, 32'h0, 32'd0);
    collect(20);
    check_val("t4_ncmd", q0.size(), 4);
    for (int i = 0; i < q0.size(); i++) begin
      check_val($sformatf("t4_cmd%0d", i), {q0[i].w, q0[i].a, q0[i].n}, {1'b0, rnd_exp[i], 11'd1});
    end
    check_val("t4_fin0", f0, 1);
    check_val("t4_cnt0", c0, 4);
    check_val("t4_busy_err0", {b0, e0}, 0);

    // Stall with an error pulse in the second stall cycle
    ready = 1'b0;
    start_test(2'b11, AM_FIX, 11'd3, 32'd10, 32'h2000, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("t5_stall%0d", i), {valid, write, addr, nwords}, {1'b1, 1'b1, 32'h2000, 11'd3});
      err = (i == 1);
      @(negedge clk);
    end
    err = 1'b0;
    check_val("t5_err_set", terr, 1);
    ready = 1'b1;
    collect(20);
    check_val("t5_ncmd", q.size(), 1);
    if (q.size() > 0) check_val("t5_cmd", {q[0].w, q[0].a}, {1'b1, 32'h2000});
    check_val("t5_fin_idx", fin_idx, 1);
    check_val("t5_err_cnt", {terr, tcnt}, {1'b1, 32'd0});

    // Zero iterations and the illegal mode
    start_test(2'b11, AM_FIX, 11'd4, 32'd0, 32'h1000, 32'd0);
    collect(10);
    check_val("t6_zero", {fin_idx, 32'(q.size()), terr, tcnt}, {32'd0, 32'd0, 1'b0, 32'd0});
    start_test(2'b00, AM_FIX, 11'd4, 32'd5, 32'h1000, 32'd0);
    collect(10);
    check_val("t6_mode00", {fin_idx, 32'(q.size()), terr}, {32'd0, 32'd0, 1'b1});

    // Start pulse while busy must not disturb the running test
    start_test(2'b10, AM_FIX, 11'd5, 32'd3, 32'h3000, 32'd0);
    test_mode = 2'b01; words = 11'd9; trans_count = 32'd1; fix_addr = 32'h5000; start = 1'b1;
    collect(20);
    check_val("t7_ncmd", q.size(), 3);
    for (int i = 0; i < q.size(); i++) begin
      check_val($sformatf("t7_cmd%0d", i), {q[i].w, q[i].a, q[i].n}, {1'b1, 32'h3000, 11'd5});
    end
    check_val("t7_cnt", tcnt, 3);

    // Asynchronous reset mid-test, then a fresh run
    start_test(2'b11, AM_FIX, 11'd4, 32'd10, 32'h4000, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("t8_rst_outs", {valid, write, addr, nwords, busy, finish, terr, tcnt}, '0);
    fin_any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fin_any |= finish;
    end
    check_val("t8_no_finish", fin_any, 0);
    rst_n = 1'b1;
    start_test(2'b10, AM_INC, 11'd1, 32'd2, 32'h100, 32'd0);
    collect(20);
    check_val("t8_ncmd", q.size(), 2);
    for (int i = 0; i < q.size(); i++) begin
      e = 32'h100 + 32'h40 * i;
      check_val($sformatf("t8_cmd%0d", i), {q[i].w, q[i].a}, {1'b1, e});
    end
    check_val("t8_fin_cnt", {fin_idx, tcnt}, {32'd2, 32'd2});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trans_sched.md
Name: trans_sched

Overview:
- Sequences one memory-check test.
- On start it latches the test configuration and generates the address stream for the selected address mode (fixed, random, running-0, running-1, incrementing).
- Issues write and/or read burst commands to the Avalon-MM transmitter over a valid/ready handshake.
- Counts completed iterations, aborts on a compare error and reports finish to the CSR block.
- Sits between the CSR register file and the AMM transmitter/compare path.

Parameters:
- ADDR_W, 32: command address width, byte address; legal range 8..32.
- BURST_W, 11: AMM burstcount width.
- ALIGN_W, 6: low address bits forced to zero; log2 of the bus width in bytes.
- CNT_W, 32: transaction counter width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  start pulse; ignored while busy_o=1
- test_mode_i  in  2  test_mode_t (01 RD only, 10 WR only, 11 WR+check)
- addr_mode_i  in  3  addr_mode_t
- words_i  in  BURST_W  words per burst; value 0 is treated as 1
- trans_count_i  in  CNT_W  number of address iterations
- fix_addr_i  in  ADDR_W  fixed / base address
- rnd_seed_i  in  32  LFSR seed; value 0 is replaced by 1
- err_i  in  1  compare-error pulse
- cmd_valid_o  out  1  command valid
- cmd_ready_i  in  1  transmitter ready
- cmd_write_o  out  1  1 = write burst, 0 = read burst
- cmd_addr_o  out  ADDR_W  burst start address
- cmd_words_o  out  BURST_W  burst length
- busy_o  out  1  test running
- finish_o  out  1  one-cycle pulse at test end
- test_err_o  out  1  sticky error flag; cleared on accepted start
- trans_cnt_o  out  CNT_W  completed iterations; cleared on accepted start, held after finish

Behaviour:
- Reset: all outputs 0, FSM in IDLE, LFSR = 1, bit index = ALIGN_W, counter = 0.
- Reset mid-test: immediate return to the reset state; no finish_o pulse is generated.
- FSM states: IDLE, WR, RD, DONE.
- IDLE, start_i=1:
  - Latch all *_i configuration inputs; clear test_err_o and trans_cnt_o; set busy_o.
  - trans_count_i=0 or test_mode_i=00: go to DONE; for mode 00, also set test_err_o.
  - Otherwise go to WR (modes 10, 11) or RD (mode 01).
  - cmd_valid_o rises the cycle after start is accepted.
- WR: cmd_write_o=1. On handshake, go to RD (mode 11) or complete the iteration (mode 10).
- RD: cmd_write_o=0. On handshake, complete the iteration.
- Mode 11: WR and RD use the same address.
- Completing an iteration:
  - trans_cnt_o increments and the address generator advances.
  - If the count reaches the latched trans_count, go to DONE.
  - Otherwise go to WR or RD, with cmd_valid_o held high (back-to-back, one command per cycle when ready=1).
- DONE, one cycle: finish_o=1, busy_o=0, then IDLE.
- Handshake: a transfer occurs on cmd_valid_o & cmd_ready_i. While valid=1 and ready=0, all cmd_* outputs hold stable and valid never drops.
- cmd_words_o is the latched words value, or 1 if it was 0.
- Address modes (low ALIGN_W bits always zero):
  - FIX: fix_addr.
  - INC: fix_addr + n*(words<<ALIGN_W) for iteration n; wraps mod 2^ADDR_W.
  - RUN_1: only bit k set. k starts at ALIGN_W, increments per iteration, and after ADDR_W-1 wraps to ALIGN_W.
  - RUN_0: all ones except bit k.
  - RND: the address is the LFSR's low ADDR_W bits.
    - The first address is the seed.
    - Next value = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
  - Codes 101..111: treated as FIX.
- err_i:
  - Sampled only while busy_o=1; it sets test_err_o.
  - If cmd_valid_o=0, go to DONE next cycle.
  - If cmd_valid_o=1, finish the pending handshake, do not count a partial WR+RD pair, then go to DONE.
  - err_i in IDLE is ignored.
- start_i coincident with DONE or while busy: ignored.

Test Plan:
- Mode 11, FIX, fix_addr=0x1000, words=4, count=3, ready=1 -> six consecutive handshakes W/R@0x1000 with cmd_words_o=4; finish_o the cycle after the sixth; trans_cnt_o=3; busy_o=0.
- Mode 10, INC, fix_addr=0, words=2, count=4 -> writes @0x0, 0x80, 0x100, 0x180; no reads; trans_cnt_o=4.
- Mode 01, RUN_1, count=28 -> reads @0x40, 0x80, ..., 0x8000_0000 (26 addresses), then wrap to 0x40, 0x80; RUN_0 first address = 0xFFFF_FF80.
- RND with ALIGN_W=0, seed=0, mode 01, count=4 -> addresses 0x1, 0x3, 0x6, 0xD.
- Mode 11, ready held low 5 cycles, err_i pulse in cycle 2 of the stall -> cmd_* outputs stable through the stall; one handshake on ready; no further commands; finish_o pulse; test_err_o=1; trans_cnt_o excludes the partial pair.
- count=0 -> finish_o one cycle after start with no commands.
- start_i while busy -> no effect.
- rst_n_i low mid-burst -> all outputs 0 asynchronously, no finish_o; a fresh start afterwards runs normally.
